// File: rtl/riscv_regfile_scoreboard.sv
// Multi-ported register file with a per-register busy (pending-write) bit.
// Integer registers sit in the lower half of the address space; with an FP bank
// the address MSB selects the FP half. Address 0 is hard-wired to zero.
module riscv_regfile_scoreboard #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RPORTS = 3,
    parameter int NUM_WPORTS = 2,
    parameter int FPU        = 0,
    parameter int Zfinx      = 0,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [NUM_WPORTS-1:0]            we_i,
    input  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i,
    input  logic                             rsv_valid_i,
    input  logic [ADDR_WIDTH-1:0]            rsv_addr_i,
    input  logic                             flush_i,
    output logic                             wconflict_o
);

    // A separate FP bank doubles the register count; otherwise the upper half is unmapped.
    localparam int NUM_TOT_WORDS = (FPU == 1 && Zfinx == 0) ? 2 ** ADDR_WIDTH
                                                            : 2 ** (ADDR_WIDTH - 1);

    // Word 0 is never stored, so the arrays start at index 1.
    logic [DATA_WIDTH-1:0]      mem_q   [1:NUM_TOT_WORDS-1];
    logic [NUM_TOT_WORDS-1:1]   busy_q;
    logic [DATA_WIDTH-1:0]      wr_data [1:NUM_TOT_WORDS-1];
    logic [NUM_TOT_WORDS-1:1]   wr_en;
    logic [NUM_TOT_WORDS-1:1]   rsv_hit;
    logic                       conflict_d;

    function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (32'(a) < NUM_TOT_WORDS);
    endfunction

    // Resolve the write ports per word; ascending port order lets the highest port win.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        wr_en   = '0;
        rsv_hit = '0;
        for (int i = 1; i < NUM_TOT_WORDS; i++) begin
            wr_data[i] = '0;
            rsv_hit[i] = rsv_valid_i && (rsv_addr_i == ADDR_WIDTH'(i));
            for (int w = 0; w < NUM_WPORTS; w++) begin
                if (we_i[w] && waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
                    wr_en[i]   = 1'b1;
                    wr_data[i] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Flag any pair of enabled write ports hitting the same mapped, non-zero register.
    always_comb begin
        conflict_d = 1'b0;
        for (int w = 0; w < NUM_WPORTS; w++) begin
            for (int v = w + 1; v < NUM_WPORTS; v++) begin
                if (we_i[w] && we_i[v] &&
                    addr_valid(waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH]) &&
                    waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH] == waddr_i[v*ADDR_WIDTH +: ADDR_WIDTH])
                    conflict_d = 1'b1;
            end
        end
    end

    // Read mux; unmatched addresses (0 and unmapped) fall through to zero / not busy.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            for (int i = 1; i < NUM_TOT_WORDS; i++) begin
                if (raddr_i[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(i)) begin
                    if (BYPASS == 1 && wr_en[i]) begin
                        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = wr_data[i];
                        rbusy_o[p]                          = 1'b0;
                    end else begin
                        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
                        rbusy_o[p]                          = busy_q[i];
                    end
                end
            end
        end
    end

    // Register storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the storage is flops, not RAM, so it can be cleared asynchronously like any other state.
            for (int i = 1; i < NUM_TOT_WORDS; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_TOT_WORDS; i++)
                if (wr_en[i]) mem_q[i] <= wr_data[i];
        end
    end

    // Busy bits: reserve beats flush, flush beats write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < NUM_TOT_WORDS; i++) begin
                if (rsv_hit[i])    busy_q[i] <= 1'b1;
                else if (flush_i)  busy_q[i] <= 1'b0;
                else if (wr_en[i]) busy_q[i] <= 1'b0;
            end
        end
    end

    // Registered write-conflict indication, visible for the cycle after the collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wconflict_o <= 1'b0;
        else        wconflict_o <= conflict_d;
    end

endmodule

// File: tb/tb_riscv_regfile_scoreboard.sv
// Scoreboard bench: three instances share stimulus (default, no-bypass, FP bank).
// Stimulus pushes expected outputs into a queue; the monitor checks them on the
// falling edge of the same cycle.
module tb_riscv_regfile_scoreboard;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int NR = 3;
    localparam int NW = 2;

    localparam int I_DEF = 0;  // BYPASS=1, FPU=0
    localparam int I_NB  = 1;  // BYPASS=0, FPU=0
    localparam int I_FP  = 2;  // BYPASS=1, FPU=1

    logic              clk;
    logic              rst_n;
    logic [NR*AW-1:0]  raddr;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic              flush;

    logic [NR*DW-1:0]  rdata_a [3];
    logic [NR-1:0]     rbusy_a [3];
    logic              wconf_a [3];

    typedef struct {
        string       name;
        int          inst;
        int          port;
        bit          is_conf;
        logic [31:0] data;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    riscv_regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR),
        .NUM_WPORTS(NW), .FPU(0), .Zfinx(0), .BYPASS(1)) dut_def (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_a[I_DEF]),
        .rbusy_o(rbusy_a[I_DEF]), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .flush_i(flush),
        .wconflict_o(wconf_a[I_DEF]));

    riscv_regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR),
        .NUM_WPORTS(NW), .FPU(0), .Zfinx(0), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_a[I_NB]),
        .rbusy_o(rbusy_a[I_NB]), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .flush_i(flush),
        .wconflict_o(wconf_a[I_NB]));

    riscv_regfile_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR),
        .NUM_WPORTS(NW), .FPU(1), .Zfinx(0), .BYPASS(1)) dut_fp (
        .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_a[I_FP]),
        .rbusy_o(rbusy_a[I_FP]), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr), .flush_i(flush),
        .wconflict_o(wconf_a[I_FP]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: drain every expectation queued during this cycle and compare.
    exp_t        e;
    logic [31:0] got_d;
    logic        got_b;
    always @(negedge clk) begin
        while (q.size() > 0) begin
            e = q.pop_front();
            n_tests++;
            if (e.is_conf) begin
                got_b = wconf_a[e.inst];
                if (got_b !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s (inst %0d): wconflict got %b expected %b",
                             e.name, e.inst, got_b, e.busy);
                end
            end else begin
                got_d = rdata_a[e.inst][e.port*DW +: DW];
                got_b = rbusy_a[e.inst][e.port];
                if (got_d !== e.data || got_b !== e.busy) begin
                    n_fail++;
                    $display("FAIL %s (inst %0d port %0d): got data %h busy %b expected data %h busy %b",
                             e.name, e.inst, e.port, got_d, got_b, e.data, e.busy);
                end
            end
        end
    end

    task automatic exp_rd(input string n, input int inst, input int port,
                          input logic [31:0] d, input logic b);
        exp_t x;
        x.name = n; x.inst = inst; x.port = port; x.is_conf = 1'b0; x.data = d; x.busy = b;
        q.push_back(x);
    endtask

    task automatic exp_cf(input string n, input int inst, input logic c);
        exp_t x;
        x.name = n; x.inst = inst; x.port = 0; x.is_conf = 1'b1; x.data = '0; x.busy = c;
        q.push_back(x);
    endtask

    task automatic idle();
        we = '0; waddr = '0; wdata = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        raddr[p*AW +: AW] = AW'(a);
    endtask

    task automatic wr(input int w, input int a, input logic [31:0] d);
        we[w] = 1'b1;
        waddr[w*AW +: AW] = AW'(a);
        wdata[w*DW +: DW] = d;
    endtask

    task automatic rsv(input int a);
        rsv_valid = 1'b1;
        rsv_addr  = AW'(a);
    endtask

    // Advance one clock and return inputs to idle shortly after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        raddr = '0;
        idle();

        // Reset state.
        set_rd(0, 1); set_rd(1, 5); set_rd(2, 7);
        exp_rd("rst_r1", I_DEF, 0, 32'h0, 1'b0);
        exp_rd("rst_r5", I_DEF, 1, 32'h0, 1'b0);
        exp_rd("rst_r7", I_DEF, 2, 32'h0, 1'b0);
        exp_cf("rst_conf", I_DEF, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reserve 5: not visible until the next edge.
        raddr = '0;
        rsv(5); set_rd(0, 5);
        exp_rd("rsv5_same", I_DEF, 0, 32'h0, 1'b0);
        tick();
        set_rd(0, 5);
        exp_rd("rsv5_busy", I_DEF, 0, 32'h0, 1'b1);
        exp_rd("rsv5_busy_nb", I_NB, 0, 32'h0, 1'b1);
        tick();

        // Write 5 clears busy; bypass vs stored view in the write cycle.
        wr(0, 5, 32'hDEADBEEF); set_rd(0, 5);
        exp_rd("wr5_byp", I_DEF, 0, 32'hDEADBEEF, 1'b0);
        exp_rd("wr5_nobyp", I_NB, 0, 32'h0, 1'b1);
        tick();
        set_rd(0, 5);
        exp_rd("wr5_after", I_DEF, 0, 32'hDEADBEEF, 1'b0);
        exp_rd("wr5_after_nb", I_NB, 0, 32'hDEADBEEF, 1'b0);
        exp_rd("wr5_after_fp", I_FP, 0, 32'hDEADBEEF, 1'b0);
        tick();

        // Two ports write 7: port 1 wins, conflict flagged for exactly one cycle.
        wr(0, 7, 32'h11); wr(1, 7, 32'h22); set_rd(1, 7);
        exp_rd("conf7_byp", I_DEF, 1, 32'h22, 1'b0);
        exp_cf("conf7_pre", I_DEF, 1'b0);
        tick();
        set_rd(1, 7);
        exp_rd("conf7_word", I_DEF, 1, 32'h22, 1'b0);
        exp_rd("conf7_word_nb", I_NB, 1, 32'h22, 1'b0);
        exp_cf("conf7_flag", I_DEF, 1'b1);
        exp_cf("conf7_flag_nb", I_NB, 1'b1);
        tick();
        exp_cf("conf7_clear", I_DEF, 1'b0);
        tick();

        // Same-cycle bypass of 3 = 0xA5 on write port 1.
        wr(1, 3, 32'hA5); set_rd(2, 3);
        exp_rd("byp3", I_DEF, 2, 32'hA5, 1'b0);
        exp_rd("byp3_nb_old", I_NB, 2, 32'h0, 1'b0);
        tick();
        set_rd(2, 3);
        exp_rd("byp3_after_nb", I_NB, 2, 32'hA5, 1'b0);
        tick();

        // Reserve and write 9 together: busy stays set, data written.
        rsv(9); wr(0, 9, 32'h99);
        tick();
        rsv(10); set_rd(0, 9); set_rd(1, 10);
        exp_rd("rsvwr9", I_DEF, 0, 32'h99, 1'b1);
        exp_rd("rsv10_pre", I_DEF, 1, 32'h0, 1'b0);
        tick();

        // Flush with reserve 4 (and a write to 6 that must still land).
        flush = 1'b1; rsv(4); wr(0, 6, 32'h66);
        set_rd(0, 9); set_rd(1, 10); set_rd(2, 4);
        exp_rd("flush_pre9", I_NB, 0, 32'h99, 1'b1);
        exp_rd("flush_pre10", I_NB, 1, 32'h0, 1'b1);
        tick();
        set_rd(0, 9); set_rd(1, 10); set_rd(2, 4);
        exp_rd("flush_9", I_DEF, 0, 32'h99, 1'b0);
        exp_rd("flush_10", I_DEF, 1, 32'h0, 1'b0);
        exp_rd("flush_4", I_DEF, 2, 32'h0, 1'b1);
        tick();

        // Address 0: write and reserve ignored, bypass never forwards.
        wr(0, 0, 32'hFF); rsv(0); set_rd(0, 0); set_rd(1, 6);
        exp_rd("r0_byp", I_DEF, 0, 32'h0, 1'b0);
        exp_rd("flush_wr6", I_DEF, 1, 32'h66, 1'b0);
        tick();
        set_rd(0, 0);
        exp_rd("r0_after", I_DEF, 0, 32'h0, 1'b0);
        exp_rd("r0_after_nb", I_NB, 0, 32'h0, 1'b0);
        tick();

        // Address 33: FP register 1 when FPU=1, unmapped otherwise.
        wr(0, 33, 32'h3F800000); set_rd(0, 33); set_rd(1, 1);
        exp_rd("fp33_byp", I_FP, 0, 32'h3F800000, 1'b0);
        exp_rd("fp33_unmapped_byp", I_DEF, 0, 32'h0, 1'b0);
        tick();
        set_rd(0, 33); set_rd(1, 1);
        exp_rd("fp33", I_FP, 0, 32'h3F800000, 1'b0);
        exp_rd("fp_int1", I_FP, 1, 32'h0, 1'b0);
        exp_rd("int33_unmapped", I_DEF, 0, 32'h0, 1'b0);
        exp_rd("int1", I_DEF, 1, 32'h0, 1'b0);
        tick();

        // Reset asserted in the middle of a conflicting write plus reserve.
        wr(0, 8, 32'h88); wr(1, 8, 32'h89); rsv(11);
        set_rd(0, 5); set_rd(1, 7); set_rd(2, 3);
        #1;
        rst_n = 1'b0;
        exp_rd("midrst_r5", I_DEF, 0, 32'h0, 1'b0);
        exp_rd("midrst_r7", I_DEF, 1, 32'h0, 1'b0);
        exp_rd("midrst_r3", I_NB, 2, 32'h0, 1'b0);
        exp_cf("midrst_conf", I_DEF, 1'b0);
        tick();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_rd(0, 8); set_rd(1, 11); set_rd(2, 33);
        exp_rd("postrst_r8", I_DEF, 0, 32'h0, 1'b0);
        exp_rd("postrst_r11", I_DEF, 1, 32'h0, 1'b0);
        exp_rd("postrst_fp33", I_FP, 2, 32'h0, 1'b0);
        exp_cf("postrst_conf", I_DEF, 1'b0);
        exp_cf("postrst_conf_fp", I_FP, 1'b0);
        tick();

        @(negedge clk);
        #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_regfile_scoreboard.md
RISCV_REGFILE_SCOREBOARD -- requirements
Module: riscv_regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 6, register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 The block SHALL have parameter NUM_RPORTS, default 3, number of read ports (1..4).
REQ-004 The block SHALL have parameter NUM_WPORTS, default 2, number of write ports (1..4).
REQ-005 The block SHALL have parameter FPU, default 0; 1 adds the FP bank.
REQ-006 The block SHALL have parameter Zfinx, default 0; 1 means FP operands use the integer bank.
REQ-007 The block SHALL have parameter BYPASS, default 1; 1 forwards same-cycle write data to reads.
REQ-008 The block SHALL have port clk, input, 1, the single clock, with all state on its rising edge.
REQ-009 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 The block SHALL have port raddr_i, input, NUM_RPORTS*ADDR_WIDTH, read addresses, port p at slice p.
REQ-011 The block SHALL have port rdata_o, output, NUM_RPORTS*DATA_WIDTH, read data.
REQ-012 The block SHALL have port rbusy_o, output, NUM_RPORTS, pending-write flag of each read address.
REQ-013 The block SHALL have port we_i, input, NUM_WPORTS, write enables.
REQ-014 The block SHALL have port waddr_i, input, NUM_WPORTS*ADDR_WIDTH, write addresses.
REQ-015 The block SHALL have port wdata_i, input, NUM_WPORTS*DATA_WIDTH, write data.
REQ-016 The block SHALL have port rsv_valid_i, input, 1, reserve a destination at issue.
REQ-017 The block SHALL have port rsv_addr_i, input, ADDR_WIDTH, address to reserve.
REQ-018 The block SHALL have port flush_i, input, 1, clear all reservations.
REQ-019 The block SHALL have port wconflict_o, output, 1, registered flag for same-address multi-port write.

Function
REQ-020 NUM_TOT_WORDS SHALL be 2^ADDR_WIDTH when FPU=1 and Zfinx=0, otherwise 2^(ADDR_WIDTH-1); the MSB then selects the FP bank.
REQ-021 Storage SHALL be flip-flops clocked by clk, one DATA_WIDTH word and one busy bit per address below NUM_TOT_WORDS.
REQ-022 Address 0 SHALL always read 0 with busy 0; writes and reserves to address 0 SHALL be ignored; FP address NUM_TOT_WORDS/2 is a normal register.
REQ-023 Addresses >= NUM_TOT_WORDS SHALL read 0 with busy 0 and SHALL be ignored on write or reserve.
REQ-024 A write with we_i[w]=1 SHALL update the word at the next rising edge; reads SHALL be combinational from stored state.
REQ-025 When several write ports target the same valid address in one cycle, the highest-indexed port SHALL win, and wconflict_o SHALL be 1 for exactly the following cycle.
REQ-026 With BYPASS=1, a read whose address matches an active write in the same cycle SHALL return the winning write data with rbusy 0; with BYPASS=0 it SHALL return stored data and stored busy.
REQ-027 A write SHALL clear the address's busy bit at the next edge; a write to a non-busy register is legal.
REQ-028 rsv_valid_i SHALL set busy[rsv_addr_i] at the next edge.
REQ-029 Busy bits SHALL follow this priority, highest first: reserve set, flush clear, write clear; a reserve and a write to the same address in one cycle leaves busy 1 and the data written.
REQ-030 flush_i SHALL clear all busy bits at the next edge; writes in that cycle still update data.
REQ-031 The block SHALL have no stall or backpressure and SHALL accept every request every cycle.

Reset
REQ-032 While rst_n=0, all words, all busy bits and wconflict_o SHALL be 0 asynchronously, so that rdata_o and rbusy_o read 0.
REQ-033 A write or reserve in flight when reset asserts SHALL be discarded; operation SHALL resume at the first rising edge after rst_n deasserts.

Verification
REQ-034 The bench SHALL cover: reserve 5, next cycle read 5 -> rbusy 1; write 5=0xDEADBEEF -> next cycle rdata 0xDEADBEEF, rbusy 0.
REQ-035 The bench SHALL cover: ports 0 and 1 both write 7 (0x11, 0x22) -> word 7=0x22, wconflict_o=1 for one cycle.
REQ-036 The bench SHALL cover: BYPASS=1, write 3=0xA5 and read 3 in the same cycle -> rdata 0xA5, rbusy 0; BYPASS=0 -> old value.
REQ-037 The bench SHALL cover: reserve 9 and write 9 in the same cycle -> busy 1; flush plus reserve 4 -> only busy[4] set.
REQ-038 The bench SHALL cover: write 0=0xFF -> reads 0; FPU=1, write 33=0x3F800000 -> FP bank only, and integer 1 unchanged.
REQ-039 The bench SHALL cover: reset asserted mid-write -> all reads 0, no busy bits, wconflict_o 0.
